// File: rtl/hexword_serialiser.sv
// Serialises a binary word into ASCII hex characters, most significant digit first,
// with an optional 0x prefix, leading-zero suppression and terminator.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | waiting for a start; ready high, no character presented
// S_PFX0  | presenting '0' of the 0x prefix
// S_PFXX  | presenting 'x' of the 0x prefix
// S_DIGIT | presenting the nibble at r_idx as a hex character
// S_TERM  | presenting the terminator character
module hexword_serialiser #(
    parameter int                   WORD_BITS      = 32,
    parameter int                   CHAR_SIZE      = 8,
    parameter bit                   UPPERCASE      = 1'b0,
    parameter bit                   PREFIX         = 1'b0,
    parameter bit                   SUPPRESS_ZEROS = 1'b0,
    parameter logic [CHAR_SIZE-1:0] TERMINATOR     = '0
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_start,
    input  logic [WORD_BITS-1:0] in_word,
    output logic                 out_ready,
    output logic [CHAR_SIZE-1:0] out_char,
    output logic                 out_char_valid,
    input  logic                 in_char_ready,
    output logic                 out_done
);

    localparam int NUM_DIGITS = (WORD_BITS + 3) / 4;
    localparam int PAD_BITS   = 4 * NUM_DIGITS;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFXX,
        S_DIGIT,
        S_TERM
    } state_t;

    state_t               r_state;
    logic [PAD_BITS-1:0]  r_word;
    logic [IDX_W-1:0]     r_idx;
    logic [CHAR_SIZE-1:0] r_char;
    logic                 r_valid;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [PAD_BITS-1:0]  w_word_ext;
    logic [PAD_BITS-1:0]  w_word_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_done_nxt;
    logic                 w_hs;
    logic [3:0]           w_nib;
    logic [7:0]           w_digit;
    logic [CHAR_SIZE-1:0] w_char_nxt;

    // Index of the most significant nonzero nibble, 0 for an all-zero word.
    function automatic logic [IDX_W-1:0] msnz_index(input logic [PAD_BITS-1:0] word);
        msnz_index = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word[4*i +: 4] != 4'd0) msnz_index = IDX_W'(i);
        end
    endfunction

    assign w_word_ext     = PAD_BITS'(in_word);
    assign w_hs           = r_valid && in_char_ready;
    assign out_ready      = (r_state == S_IDLE);
    assign out_char       = r_char;
    assign out_char_valid = r_valid;
    assign out_done       = r_done;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_idx   <= '0;
            r_char  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_idx   <= w_idx_nxt;
            r_char  <= w_char_nxt;
            r_valid <= (w_state_nxt != S_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_start) begin
                    w_word_nxt  = w_word_ext;
                    w_idx_nxt   = SUPPRESS_ZEROS ? msnz_index(w_word_ext) : IDX_W'(NUM_DIGITS - 1);
                    w_state_nxt = PREFIX ? S_PFX0 : S_DIGIT;
                end
            end
            S_PFX0: if (w_hs) w_state_nxt = S_PFXX;
            S_PFXX: if (w_hs) w_state_nxt = S_DIGIT;
            S_DIGIT: begin
                if (w_hs) begin
                    if (r_idx != '0) begin
                        w_idx_nxt = r_idx - 1'b1;
                    end else if (TERMINATOR != '0) begin
                        w_state_nxt = S_TERM;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_TERM: begin
                if (w_hs) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The character register is loaded from the next state so it lines up with r_valid.
    always_comb begin
        w_nib      = w_word_nxt[{w_idx_nxt, 2'b00} +: 4];
        w_digit    = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                     : ((UPPERCASE ? 8'h41 : 8'h61) + {4'h0, w_nib} - 8'd10);
        w_char_nxt = '0;
        case (w_state_nxt)
            S_PFX0:  w_char_nxt = CHAR_SIZE'(8'h30);
            S_PFXX:  w_char_nxt = CHAR_SIZE'(8'h78);
            S_DIGIT: w_char_nxt = CHAR_SIZE'(w_digit);
            S_TERM:  w_char_nxt = TERMINATOR;
            default: w_char_nxt = '0;
        endcase
    end

endmodule

// File: doc/hexword_serialiser.md
# hexword_serialiser

Converts a parametrised-width binary word into a stream of ASCII hex characters, emitted one character per accepted handshake, most significant digit first. Optional features: `0x` prefix, upper-case digits, leading-zero suppression and a terminator character. It sits between numeric datapaths (counters, registers, sensor values) and character sinks such as the UART transmitter or the LCD/text-console drivers. It replaces per-nibble combinational lookup plus ad-hoc sequencing in each client.

## Interface

Parameters:
- `WORD_BITS`, 32: width of the input word. Digit count is `NUM_DIGITS = ceil(WORD_BITS/4)`. The word is zero-extended at the MSB end to `4*NUM_DIGITS` bits.
- `CHAR_SIZE`, 8: width of the output character. Must be ≥ 7.
- `UPPERCASE`, 0: 1 emits `A`–`F`; 0 emits `a`–`f`.
- `PREFIX`, 0: 1 emits `0`,`x` before the digits. The `x` is always lower case.
- `SUPPRESS_ZEROS`, 0: 1 skips leading zero digits. At least one digit is always emitted.
- `TERMINATOR`, 0: if nonzero, this character code is emitted after the last digit.

Ports:
- `in_clk` in 1: clock; all state changes on the rising edge.
- `in_rst_n` in 1: reset, asynchronous and active-low.
- `in_start` in 1: request to convert `in_word`.
- `in_word` in WORD_BITS: value to convert. Sampled only when a start is accepted.
- `out_ready` out 1: high when the block can accept `in_start`.
- `out_char` out CHAR_SIZE: current character. Registered.
- `out_char_valid` out 1: `out_char` is valid.
- `in_char_ready` in 1: the downstream sink accepts `out_char` this cycle.
- `out_done` out 1: one-cycle pulse after the final character has been accepted.

## Operation

- Start is accepted when `in_start && out_ready` at a rising edge. On acceptance:
  - `in_word` is latched.
  - The first state is selected: PFX0 if `PREFIX`, else DIGIT if `TERMINATOR` is irrelevant to the choice.
  - The digit index is set.
- Digit index on acceptance:
  - `NUM_DIGITS-1` when `SUPPRESS_ZEROS=0`.
  - Otherwise, the index of the most significant nonzero nibble, or 0 if the word is zero. A priority encoder computes this in the accept cycle, so no skip cycles occur.
- States:
  - IDLE: `out_ready=1`, `out_char_valid=0`.
  - PFX0: presents `0`.
  - PFXX: presents `x`.
  - DIGIT: presents the nibble at the digit index, mapped to `0`–`9` / `a`–`f` or `A`–`F`.
  - TERM: presents `TERMINATOR`.
- Transitions occur only on a character handshake (`out_char_valid && in_char_ready`):
  - PFX0 → PFXX.
  - PFXX → DIGIT.
  - DIGIT with index > 0 → DIGIT with index-1.
  - DIGIT with index 0 → TERM if `TERMINATOR≠0`, else → IDLE.
  - TERM → IDLE.
- On the transition into IDLE, `out_done` pulses for one cycle.
- `out_char` and `out_char_valid` stay stable while `in_char_ready=0`.
- `in_start` while not ready is ignored; no queuing.
- Changes to `in_word` after acceptance have no effect.
- `in_char_ready` while `out_char_valid=0` has no effect.

## Timing

- Reset values: `out_ready=1`, `out_char=0`, `out_char_valid=0`, `out_done=0`, state IDLE.
- Reset asserted mid-transfer aborts the transfer immediately: no `out_done`, no further characters.
- Start accepted at edge k: first character valid from edge k (visible in cycle k+1). `out_ready=0` from edge k.
- With `in_char_ready` held high, characters change every cycle with no bubbles.
- Total characters: `2*PREFIX + digits + (TERMINATOR≠0)`, where digits is `NUM_DIGITS` or the suppressed count.
- Final handshake at edge m:
  - `out_char_valid=0`, `out_done=1` and `out_ready=1` during cycle m+1.
  - A new start can be accepted at edge m+1.
- Minimum period between starts is N+1 cycles for N characters.
- Simultaneous `in_start` with the final handshake is not accepted, because `out_ready` is still 0 in that cycle.

## Test plan

- `WORD_BITS=16`, defaults, `in_word=0xBEEF`, ready tied high, start at edge k:
  - Characters `b`,`e`,`e`,`f` in cycles k+1..k+4.
  - `out_done=1` and `out_ready=1` in cycle k+5.
- Same word with `in_char_ready` pattern 0,1,0,0,1,1,0,1:
  - Each character is held until its handshake.
  - No character is duplicated or lost.
  - `out_done` pulses once.
- `PREFIX=1`, `UPPERCASE=1`, `SUPPRESS_ZEROS=1`, `TERMINATOR=8'h0A`, `WORD_BITS=16`, `in_word=0x00A5`:
  - Output is `0`,`x`,`A`,`5`,`0x0A`, five characters in five cycles.
- `SUPPRESS_ZEROS=1`, `in_word=0`:
  - Exactly one `0` character, then `out_done`.
- `WORD_BITS=10`, `in_word=10'h3FF`:
  - Output is `3`,`f`,`f`.
  - Then `in_word=0`, no suppression: output is `0`,`0`,`0`.
- Reset and start rules:
  - `in_start` pulsed mid-transfer with a different `in_word`: ignored, and the original stream completes.
  - `in_rst_n` low after the second character: outputs go immediately to reset values, no `out_done`.
  - After reset release, a new start behaves normally.
